bp_me_dma_arbiter: RTL and testbench

- N-to-1 DMA concentrator between the L2 cache banks' bsg_cache DMA ports and a single-channel DRAM model or controller.
- Round-robin arbitrates packets from num_dma_p channels onto one DMA channel.
- Records each grant's channel id in read/write tag FIFOs, so returned read fill beats reach the correct bank and write fill beats are taken from the correct bank in grant order.

---
 rtl/bp_me_dma_pkg.sv | 16 +
 rtl/bp_me_dma_tag_fifo.sv | 54 +++++
 rtl/bp_me_dma_arbiter.sv | 128 ++++++++++++
 tb/tb_bp_me_dma_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_dma_pkg.sv
// Shared types and helpers for the DMA concentrator and its tag FIFOs.
package bp_me_dma_pkg;

    localparam int DMA_DADDR_W = 28;
    localparam int DMA_FILL_W  = 64;

    typedef struct packed {
        logic                   write_not_read;
        logic [DMA_DADDR_W-1:0] addr;
    } bp_dma_pkt_s;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_me_dma_tag_fifo.sv
// Small 1r1w FIFO holding channel ids of granted packets, oldest first.
module bp_me_dma_tag_fifo
    import bp_me_dma_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = safe_clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0] r_mem;
    logic [ptr_w_lp-1:0]           r_rptr, r_wptr;
    logic [cnt_w_lp-1:0]           r_cnt;
    logic                          w_push, w_pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign full_o  = (r_cnt == cnt_w_lp'(els_p));
    assign empty_o = (r_cnt == '0);
    assign data_o  = r_mem[r_rptr];
    // A push into a full FIFO is only accepted alongside a pop.
    assign w_push  = v_i & (~full_o | yumi_i);
    assign w_pop   = yumi_i & ~empty_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mem  <= '0;
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + cnt_w_lp'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - cnt_w_lp'(1);
        end
    end

endmodule

// File: rtl/bp_me_dma_arbiter.sv
// N-to-1 round-robin DMA concentrator; tag FIFOs steer read fills back and pick
// the write-data source in grant order.
module bp_me_dma_arbiter
    import bp_me_dma_pkg::*;
#(
    parameter int num_dma_p            = 2,
    parameter int daddr_width_p        = DMA_DADDR_W,
    parameter int fill_width_p         = DMA_FILL_W,
    parameter int block_size_in_fill_p = 8,
    parameter int tag_fifo_els_p       = 4,
    localparam int pkt_width_lp        = daddr_width_p + 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [num_dma_p-1:0][pkt_width_lp-1:0]    dma_pkt_i,
    input  logic [num_dma_p-1:0]                      dma_pkt_v_i,
    output logic [num_dma_p-1:0]                      dma_pkt_yumi_o,
    output logic [num_dma_p-1:0][fill_width_p-1:0]    dma_data_o,
    output logic [num_dma_p-1:0]                      dma_data_v_o,
    input  logic [num_dma_p-1:0]                      dma_data_ready_and_i,
    input  logic [num_dma_p-1:0][fill_width_p-1:0]    dma_data_i,
    input  logic [num_dma_p-1:0]                      dma_data_v_i,
    output logic [num_dma_p-1:0]                      dma_data_yumi_o,
    output logic [pkt_width_lp-1:0]                   mem_pkt_o,
    output logic                                      mem_pkt_v_o,
    input  logic                                      mem_pkt_yumi_i,
    input  logic [fill_width_p-1:0]                   mem_data_i,
    input  logic                                      mem_data_v_i,
    output logic                                      mem_data_ready_and_o,
    output logic [fill_width_p-1:0]                   mem_data_o,
    output logic                                      mem_data_v_o,
    input  logic                                      mem_data_yumi_i
);

    localparam int lg_num_dma_lp = safe_clog2(num_dma_p);
    localparam int lg_block_lp   = safe_clog2(block_size_in_fill_p);

    logic [lg_num_dma_lp-1:0] r_rr, w_grant, w_hi, w_lo, w_rhead, w_whead;
    logic [lg_block_lp-1:0]   r_rcnt, r_wcnt;
    logic [num_dma_p-1:0]     w_elig;
    logic                     w_gnt_v, w_hi_v, w_gnt_wr;
    logic                     w_rfull, w_rempty, w_wfull, w_wempty;
    logic                     w_rready, w_rhs, w_rlast, w_wv, w_whs, w_wlast;

    // Eligibility is gated by reset so no valid escapes while the FIFOs are held clear.
    for (genvar i = 0; i < num_dma_p; i++) begin : g_ch
        assign w_elig[i] = reset_n_i & dma_pkt_v_i[i]
                         & (dma_pkt_i[i][pkt_width_lp-1] ? ~w_wfull : ~w_rfull);
        assign dma_pkt_yumi_o[i]  = mem_pkt_yumi_i & w_gnt_v & (w_grant == lg_num_dma_lp'(i));
        assign dma_data_v_o[i]    = ~w_rempty & mem_data_v_i & (w_rhead == lg_num_dma_lp'(i));
        assign dma_data_o[i]      = mem_data_i;
        assign dma_data_yumi_o[i] = w_whs & (w_whead == lg_num_dma_lp'(i));
    end

    // Lowest eligible index at/after r_rr wins; otherwise lowest eligible overall (wrap).
    always_comb begin
        w_hi   = '0;
        w_hi_v = 1'b0;
        w_lo   = '0;
        for (int i = num_dma_p - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo = lg_num_dma_lp'(i);
                if (lg_num_dma_lp'(i) >= r_rr) begin
                    w_hi   = lg_num_dma_lp'(i);
                    w_hi_v = 1'b1;
                end
            end
        end
    end

    assign w_gnt_v     = |w_elig;
    assign w_grant     = w_hi_v ? w_hi : w_lo;
    assign mem_pkt_v_o = w_gnt_v;
    assign mem_pkt_o   = dma_pkt_i[w_grant];
    assign w_gnt_wr    = mem_pkt_o[pkt_width_lp-1];

    assign w_rready             = ~w_rempty & dma_data_ready_and_i[w_rhead];
    assign mem_data_ready_and_o = w_rready;
    assign w_rhs                = w_rready & mem_data_v_i;
    assign w_rlast              = (r_rcnt == lg_block_lp'(block_size_in_fill_p - 1));

    assign w_wv         = ~w_wempty & dma_data_v_i[w_whead];
    assign mem_data_v_o = w_wv;
    assign mem_data_o   = dma_data_i[w_whead];
    assign w_whs        = mem_data_yumi_i & w_wv;
    assign w_wlast      = (r_wcnt == lg_block_lp'(block_size_in_fill_p - 1));

    bp_me_dma_tag_fifo #(.width_p(lg_num_dma_lp), .els_p(tag_fifo_els_p)) u_rtag (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (w_grant),
        .v_i       (mem_pkt_yumi_i & w_gnt_v & ~w_gnt_wr),
        .data_o    (w_rhead),
        .yumi_i    (w_rhs & w_rlast),
        .full_o    (w_rfull),
        .empty_o   (w_rempty)
    );

    bp_me_dma_tag_fifo #(.width_p(lg_num_dma_lp), .els_p(tag_fifo_els_p)) u_wtag (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (w_grant),
        .v_i       (mem_pkt_yumi_i & w_gnt_v & w_gnt_wr),
        .data_o    (w_whead),
        .yumi_i    (w_whs & w_wlast),
        .full_o    (w_wfull),
        .empty_o   (w_wempty)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr   <= '0;
            r_rcnt <= '0;
            r_wcnt <= '0;
        end else begin
            if (mem_pkt_yumi_i && w_gnt_v)
                r_rr <= (w_grant == lg_num_dma_lp'(num_dma_p - 1)) ? '0 : w_grant + lg_num_dma_lp'(1);
            if (w_rhs) r_rcnt <= w_rlast ? '0 : r_rcnt + lg_block_lp'(1);
            if (w_whs) r_wcnt <= w_wlast ? '0 : r_wcnt + lg_block_lp'(1);
        end
    end

    a_pkt_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_pkt_yumi_i |-> mem_pkt_v_o);
    a_data_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_data_yumi_i |-> mem_data_v_o);

endmodule

// File: tb/tb_bp_me_dma_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_bp_me_dma_arbiter;

    localparam int N  = 2;
    localparam int AW = 28;
    localparam int FW = 64;
    localparam int B  = 8;
    localparam int D  = 4;
    localparam int PW = AW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0][PW-1:0] dma_pkt;
    logic [N-1:0]         dma_pkt_v, dma_pkt_yumi;
    logic [N-1:0][FW-1:0] dma_rdata;
    logic [N-1:0]         dma_rdata_v, dma_ready;
    logic [N-1:0][FW-1:0] dma_wdata;
    logic [N-1:0]         dma_wdata_v, dma_wdata_yumi;
    logic [PW-1:0]        mem_pkt;
    logic                 mem_pkt_v, mem_pkt_yumi;
    logic [FW-1:0]        mem_rdata;
    logic                 mem_rdata_v, mem_rdata_ready;
    logic [FW-1:0]        mem_wdata;
    logic                 mem_wdata_v, mem_wdata_yumi;

    bp_me_dma_arbiter #(
        .num_dma_p(N), .daddr_width_p(AW), .fill_width_p(FW),
        .block_size_in_fill_p(B), .tag_fifo_els_p(D)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .dma_pkt_i(dma_pkt), .dma_pkt_v_i(dma_pkt_v), .dma_pkt_yumi_o(dma_pkt_yumi),
        .dma_data_o(dma_rdata), .dma_data_v_o(dma_rdata_v), .dma_data_ready_and_i(dma_ready),
        .dma_data_i(dma_wdata), .dma_data_v_i(dma_wdata_v), .dma_data_yumi_o(dma_wdata_yumi),
        .mem_pkt_o(mem_pkt), .mem_pkt_v_o(mem_pkt_v), .mem_pkt_yumi_i(mem_pkt_yumi),
        .mem_data_i(mem_rdata), .mem_data_v_i(mem_rdata_v), .mem_data_ready_and_o(mem_rdata_ready),
        .mem_data_o(mem_wdata), .mem_data_v_o(mem_wdata_v), .mem_data_yumi_i(mem_wdata_yumi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: outstanding tags in grant order, RR pointer, beats within current block
    int rq[$];
    int wq[$];
    int rr = 0, rbeat = 0, wbeat = 0;

    // observation logs taken from DUT outputs
    logic [FW-1:0] rx0[$];
    logic [FW-1:0] rx1[$];
    logic [FW-1:0] wlog[$];
    int            gnt_log[$];

    // environment driver state
    int           rd_idx = 0;
    int           wcnt_drv[N];
    logic [N-1:0] s_wy;
    logic [N-1:0] s_pyumi;
    bit           s_rhs;
    bit           pend[N];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input bit w, input int a);
        return {w, AW'(a)};
    endfunction

    always @(negedge clk) begin : cmp
        bit           any, erdy, ewv;
        int           g, c, rh, wh;
        logic [N-1:0] ey, edv, ewy;
        if (dma_rdata_v[0] && dma_ready[0]) rx0.push_back(dma_rdata[0]);
        if (dma_rdata_v[1] && dma_ready[1]) rx1.push_back(dma_rdata[1]);
        if (dma_pkt_yumi != '0) gnt_log.push_back(dma_pkt_yumi[1] ? 1 : 0);
        if (mem_wdata_v && mem_wdata_yumi) wlog.push_back(mem_wdata);
        if (!rst_n) begin
            chk("rst_pkt_v", mem_pkt_v, 0);
            chk("rst_pkt_yumi", dma_pkt_yumi, 0);
            chk("rst_rd_v", dma_rdata_v, 0);
            chk("rst_rd_ready", mem_rdata_ready, 0);
            chk("rst_wr_v", mem_wdata_v, 0);
            chk("rst_wr_yumi", dma_wdata_yumi, 0);
            rq.delete(); wq.delete();
            rr = 0; rbeat = 0; wbeat = 0;
        end else begin
            any = 0; g = 0;
            for (int k = 0; k < N; k++) begin
                c = (rr + k) % N;
                if (!any && dma_pkt_v[c] && (dma_pkt[c][PW-1] ? (wq.size() < D) : (rq.size() < D))) begin
                    any = 1; g = c;
                end
            end
            chk("pkt_v", mem_pkt_v, any);
            if (any) chk("pkt", mem_pkt, dma_pkt[g]);
            ey = '0;
            if (any && mem_pkt_yumi) ey[g] = 1'b1;
            chk("pkt_yumi", dma_pkt_yumi, ey);

            rh = (rq.size() > 0) ? rq[0] : 0;
            erdy = (rq.size() > 0) && dma_ready[rh];
            edv = '0;
            if (rq.size() > 0 && mem_rdata_v) edv[rh] = 1'b1;
            chk("rd_ready", mem_rdata_ready, erdy);
            chk("rd_v", dma_rdata_v, edv);
            if (edv != '0)
                for (int i = 0; i < N; i++) chk("rd_data", dma_rdata[i], mem_rdata);

            wh = (wq.size() > 0) ? wq[0] : 0;
            ewv = (wq.size() > 0) && dma_wdata_v[wh];
            chk("wr_v", mem_wdata_v, ewv);
            if (ewv) chk("wr_data", mem_wdata, dma_wdata[wh]);
            ewy = '0;
            if (ewv && mem_wdata_yumi) ewy[wh] = 1'b1;
            chk("wr_yumi", dma_wdata_yumi, ewy);

            if (erdy && mem_rdata_v) begin
                rbeat++;
                if (rbeat == B) begin void'(rq.pop_front()); rbeat = 0; end
            end
            if (ewv && mem_wdata_yumi) begin
                wbeat++;
                if (wbeat == B) begin void'(wq.pop_front()); wbeat = 0; end
            end
            if (any && mem_pkt_yumi) begin
                if (dma_pkt[g][PW-1]) wq.push_back(g); else rq.push_back(g);
                rr = (g + 1) % N;
            end
        end
    end

    // Environment step: observe the cycle's handshakes, then move to posedge+1.
    task automatic tick();
        @(negedge clk);
        s_rhs   = mem_rdata_v & mem_rdata_ready;
        s_wy    = dma_wdata_yumi;
        s_pyumi = dma_pkt_yumi;
        @(posedge clk);
        #1;
        if (s_rhs) rd_idx++;
        for (int i = 0; i < N; i++) begin
            if (s_wy[i]) wcnt_drv[i]++;
            dma_wdata[i] = {32'(i + 1), 32'(wcnt_drv[i])};
        end
        mem_rdata = 64'(rd_idx);
    endtask

    task automatic settle(input bit want_pkt, input bit want_wr);
        #1;
        mem_pkt_yumi   = want_pkt & mem_pkt_v;
        mem_wdata_yumi = want_wr & mem_wdata_v;
    endtask

    task automatic set_rd(input int v);
        rd_idx = v;
        mem_rdata = 64'(v);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            tick(); mem_rdata_v = 1'b1; dma_ready = '1; settle(0, 0);
        end
        tick(); mem_rdata_v = 1'b0; settle(0, 0);
    endtask

    task automatic chk_q(input string nm, input logic [FW-1:0] q[$], input logic [FW-1:0] base, input int n);
        chk(nm, 128'(q.size()), 128'(n));
        for (int k = 0; k < q.size() && k < n; k++) chk(nm, q[k], base + FW'(k));
    endtask

    initial begin
        rst_n = 1'b0;
        dma_pkt = '0; dma_pkt_v = '0; dma_ready = '0; dma_wdata = '0; dma_wdata_v = '0;
        mem_pkt_yumi = 1'b0; mem_rdata = '0; mem_rdata_v = 1'b0; mem_wdata_yumi = 1'b0;
        for (int i = 0; i < N; i++) begin wcnt_drv[i] = 0; pend[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // two simultaneous reads: ch0 then ch1, beats 0..7 to ch0 and 8..15 to ch1
        tick(); dma_pkt[0] = mk(0, 'h100); dma_pkt[1] = mk(0, 'h200); dma_pkt_v = 2'b11; settle(1, 0);
        #1 chk("p1_v", mem_pkt_v, 1); chk("p1_pkt0", mem_pkt, mk(0, 'h100)); chk("p1_yumi0", dma_pkt_yumi, 2'b01);
        tick(); dma_pkt_v = 2'b10; settle(1, 0);
        #1 chk("p1_pkt1", mem_pkt, mk(0, 'h200)); chk("p1_yumi1", dma_pkt_yumi, 2'b10);
        tick(); dma_pkt_v = '0; set_rd(0); rx0.delete(); rx1.delete();
        mem_rdata_v = 1'b1; dma_ready = 2'b11; settle(0, 0);
        repeat (17) begin tick(); settle(0, 0); end
        tick(); mem_rdata_v = 1'b0; settle(0, 0);
        chk_q("p1_rx0", rx0, 64'd0, 8);
        chk_q("p1_rx1", rx1, 64'd8, 8);

        // ch1 continuously valid, ch0 joins: grants alternate 1,0,1,0
        gnt_log.delete(); rx0.delete(); rx1.delete();
        tick(); dma_pkt[1] = mk(0, 'h300); dma_pkt_v = 2'b10; settle(1, 0);
        repeat (3) begin tick(); dma_pkt[0] = mk(0, 'h340); dma_pkt_v = 2'b11; settle(1, 0); end
        tick(); dma_pkt_v = '0; settle(0, 0);
        chk("p2_ngnt", 128'(gnt_log.size()), 4);
        for (int k = 0; k < gnt_log.size() && k < 4; k++) chk("p2_gnt", 128'(gnt_log[k]), (k % 2 == 0) ? 1 : 0);
        drain(34);
        chk("p2_rx0_n", 128'(rx0.size()), 16);
        chk("p2_rx1_n", 128'(rx1.size()), 16);

        // four outstanding reads fill the read tags; fifth waits for one block to return
        repeat (4) begin tick(); dma_pkt[0] = mk(0, 'h500); dma_pkt_v = 2'b01; settle(1, 0); end
        tick(); dma_pkt_v = 2'b01; settle(1, 0);
        #1 chk("p3_full_v", mem_pkt_v, 0); chk("p3_full_yumi", dma_pkt_yumi, 0);
        for (int b = 0; b < 8; b++) begin
            tick(); mem_rdata_v = 1'b1; dma_ready = 2'b11; settle(1, 0);
            #1 chk("p3_blocked", mem_pkt_v, 0);
        end
        tick(); mem_rdata_v = 1'b0; settle(1, 0);
        #1 chk("p3_unblock", mem_pkt_v, 1); chk("p3_unblock_yumi", dma_pkt_yumi, 2'b01);
        tick(); dma_pkt_v = '0; settle(0, 0);
        drain(34);

        // writes: ch1 then ch0 granted; ch0 data early is held off until ch1's block completes
        tick(); dma_pkt[1] = mk(1, 'h400); dma_pkt_v = 2'b10; settle(1, 0);
        #1 chk("p4_gnt1", dma_pkt_yumi, 2'b10);
        tick(); dma_pkt[0] = mk(1, 'h500); dma_pkt_v = 2'b01; settle(1, 0);
        #1 chk("p4_gnt0", dma_pkt_yumi, 2'b01);
        tick(); dma_pkt_v = '0; wlog.delete();
        for (int i = 0; i < N; i++) begin wcnt_drv[i] = 0; dma_wdata[i] = {32'(i + 1), 32'd0}; end
        dma_wdata_v = 2'b01; settle(0, 1);
        #1 chk("p4_hold_v", mem_wdata_v, 0); chk("p4_hold_yumi", dma_wdata_yumi, 0);
        repeat (2) begin
            tick(); settle(0, 1);
            #1 chk("p4_hold_yumi", dma_wdata_yumi, 0);
        end
        repeat (20) begin tick(); dma_wdata_v = 2'b11; settle(0, 1); end
        tick(); dma_wdata_v = '0; settle(0, 0);
        chk("p4_wlog_n", 128'(wlog.size()), 16);
        for (int k = 0; k < wlog.size() && k < 16; k++)
            chk("p4_wlog", wlog[k], (k < 8) ? {32'd2, 32'(k)} : {32'd1, 32'(k - 8)});

        // cache stalls for 3 cycles after beat 4; no beat lost or duplicated
        tick(); dma_pkt[0] = mk(0, 'h600); dma_pkt_v = 2'b01; settle(1, 0);
        tick(); dma_pkt_v = '0; set_rd(0); rx0.delete(); rx1.delete();
        mem_rdata_v = 1'b1; dma_ready = 2'b01; settle(0, 0);
        repeat (3) begin tick(); settle(0, 0); end
        repeat (3) begin
            tick(); dma_ready = 2'b00; settle(0, 0);
            #1 chk("p5_stall_rdy", mem_rdata_ready, 0); chk("p5_stall_v", dma_rdata_v, 2'b01);
        end
        repeat (6) begin tick(); dma_ready = 2'b01; settle(0, 0); end
        tick(); mem_rdata_v = 1'b0; settle(0, 0);
        chk_q("p5_rx0", rx0, 64'd0, 8);
        chk("p5_rx1_n", 128'(rx1.size()), 0);

        // asynchronous reset during beat 3 of a read burst
        tick(); dma_pkt[1] = mk(0, 'h700); dma_pkt_v = 2'b10; settle(1, 0);
        tick(); dma_pkt_v = '0; set_rd(0); mem_rdata_v = 1'b1; dma_ready = 2'b11; settle(0, 0);
        repeat (2) begin tick(); settle(0, 0); end
        tick(); dma_pkt[0] = mk(0, 'h800); dma_pkt_v = 2'b01; settle(0, 0);
        #1 chk("p6_pre_rdy", mem_rdata_ready, 1); chk("p6_pre_pkt_v", mem_pkt_v, 1);
        rst_n = 1'b0;
        #1;
        chk("p6_rst_rdy", mem_rdata_ready, 0);
        chk("p6_rst_rd_v", dma_rdata_v, 0);
        chk("p6_rst_pkt_v", mem_pkt_v, 0);
        chk("p6_rst_pkt_yumi", dma_pkt_yumi, 0);
        chk("p6_rst_wr_v", mem_wdata_v, 0);
        chk("p6_rst_wr_yumi", dma_wdata_yumi, 0);
        tick(); rst_n = 1'b1; dma_pkt_v = '0; mem_rdata_v = 1'b0; set_rd(0);
        rx0.delete(); rx1.delete(); settle(0, 0);
        tick(); dma_pkt[1] = mk(0, 'h900); dma_pkt_v = 2'b10; settle(1, 0);
        #1 chk("p6_regrant", dma_pkt_yumi, 2'b10);
        tick(); dma_pkt_v = '0; mem_rdata_v = 1'b1; dma_ready = 2'b11; settle(0, 0);
        repeat (9) begin tick(); settle(0, 0); end
        tick(); mem_rdata_v = 1'b0; settle(0, 0);
        chk_q("p6_rx1", rx1, 64'd0, 8);
        chk("p6_rx0_n", 128'(rx0.size()), 0);

        // random traffic against the model
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (s_pyumi[i]) pend[i] = 0;
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1;
                    dma_pkt[i] = mk(1'($urandom_range(1)), int'($urandom));
                end
                dma_pkt_v[i] = pend[i];
            end
            mem_rdata_v = ($urandom_range(3) != 0);
            dma_ready   = N'($urandom);
            dma_wdata_v = N'($urandom);
            settle($urandom_range(3) != 0, 1'($urandom_range(1)));
        end
        tick(); dma_pkt_v = '0; mem_rdata_v = 1'b0; dma_wdata_v = '0; settle(0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
